// File: rtl/uart_receive.sv
// uart_receive: oversampled 8N1 UART receiver on the IO bus; `UART_RX_STATUS_EN adds overrun flag and status register at ioaddr 1
module uart_receive #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brg_full,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       drive_en,
  output logic       rda,
  output logic       ferr
);
  localparam int SW = $clog2(OVERSAMPLE);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic rxd_m_q, rxd_s_q;
  logic [SW-1:0] sample_cnt_q, sample_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic rda_q, rda_d, ferr_q, ferr_d;
  logic mid, last, load, rd;
  assign mid = sample_cnt_q == SW'(OVERSAMPLE / 2 - 1);
  assign last = sample_cnt_q == SW'(OVERSAMPLE - 1);
  assign load = brg_full & (state_q == STOP) & last;
  assign rd = iocs & iorw & (ioaddr == 2'd0);
  assign rda = rda_q;
  assign ferr = ferr_q;
  always_comb begin
    state_d = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (!rxd_s_q) begin
        state_d = START;
        sample_cnt_d = '0;
      end
      START: if (brg_full) begin
        sample_cnt_d = mid ? '0 : sample_cnt_q + 1'b1;
        bit_cnt_d = mid ? 4'd0 : bit_cnt_q;
        state_d = !mid ? START : rxd_s_q ? IDLE : DATA;
      end
      DATA: if (brg_full) begin
        sample_cnt_d = last ? '0 : sample_cnt_q + 1'b1;
        shift_d = last ? {rxd_s_q, shift_q[7:1]} : shift_q;
        bit_cnt_d = last ? bit_cnt_q + 4'd1 : bit_cnt_q;
        state_d = (last && bit_cnt_q == 4'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (brg_full) begin
        sample_cnt_d = last ? '0 : sample_cnt_q + 1'b1;
        state_d = last ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    byte_d = load ? shift_q : byte_q;
    rda_d = load ? 1'b1 : rd ? 1'b0 : rda_q;
  end
`ifdef UART_RX_STATUS_EN
  logic st_rd, overrun_q, overrun_d;
  assign st_rd = iocs & iorw & (ioaddr == 2'd1);
  assign drive_en = rd | st_rd;
  assign rx_data = st_rd ? {5'b0, overrun_q, ferr_q, rda_q} : byte_q;
  always_comb begin
    overrun_d = (load & rda_q & ~rd) ? 1'b1 : st_rd ? 1'b0 : overrun_q;
    ferr_d = load ? ~rxd_s_q : st_rd ? 1'b0 : ferr_q;
  end
  always_ff @(posedge clk) overrun_q <= rst ? 1'b0 : overrun_d;
`else
  assign drive_en = rd;
  assign rx_data = byte_q;
  always_comb ferr_d = load ? ~rxd_s_q : ferr_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
      state_q <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      byte_q <= '0;
      rda_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rxd_m_q <= rxd;
      rxd_s_q <= rxd_m_q;
      state_q <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      byte_q <= byte_d;
      rda_q <= rda_d;
      ferr_q <= ferr_d;
    end
  end
endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed checks of uart_receive with 16x oversampling, one tick every 3 clocks
module tb_uart_receive;
  logic clk = 0, rst = 1, brg_full = 0, iocs = 0, iorw = 0, rxd = 1;
  logic [1:0] ioaddr = 2'd0;
  logic [7:0] rx_data;
  logic drive_en, rda, ferr;
  int total = 0, bad = 0, div = 0;
  uart_receive dut (
    .clk(clk), .rst(rst), .brg_full(brg_full), .iocs(iocs), .iorw(iorw),
    .ioaddr(ioaddr), .rxd(rxd), .rx_data(rx_data), .drive_en(drive_en),
    .rda(rda), .ferr(ferr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    brg_full <= (div == 2);
    div <= (div == 2) ? 0 : div + 1;
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 0;
    idle(48);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(48);
    end
    if (stop) begin
      rxd = 1;
      idle(48);
    end else begin
      rxd = 0;
      idle(36);
      rxd = 1;
      idle(12);
    end
  endtask
  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input logic exp_de, input string tag);
    @(negedge clk);
    iocs = 1;
    iorw = 1;
    ioaddr = a;
    #1;
    chk({tag, "_de"}, {7'b0, drive_en}, {7'b0, exp_de});
    chk(tag, rx_data, exp);
    @(negedge clk);
    iocs = 0;
    iorw = 0;
    ioaddr = 2'd0;
  endtask
  initial begin
    idle(4);
    rst = 0;
    idle(40 * 48);
    chk("rst_rda", {7'b0, rda}, 8'd0);
    chk("rst_ferr", {7'b0, ferr}, 8'd0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_de", {7'b0, drive_en}, 8'd0);
    send(8'hA5, 1);
    chk("a5_rda", {7'b0, rda}, 8'd1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr", {7'b0, ferr}, 8'd0);
    rd(2'd0, 8'hA5, 1, "a5_rd");
    chk("a5_rda_clr", {7'b0, rda}, 8'd0);
    chk("a5_data_keep", rx_data, 8'hA5);
    rxd = 0;
    idle(12);
    rxd = 1;
    idle(96);
    chk("glitch_rda", {7'b0, rda}, 8'd0);
    send(8'h3C, 1);
    chk("3c_rda", {7'b0, rda}, 8'd1);
    chk("3c_data", rx_data, 8'h3C);
    rd(2'd0, 8'h3C, 1, "3c_rd");
    send(8'h81, 0);
    chk("81_rda", {7'b0, rda}, 8'd1);
    chk("81_data", rx_data, 8'h81);
    chk("81_ferr", {7'b0, ferr}, 8'd1);
    rd(2'd0, 8'h81, 1, "81_rd");
    idle(96);
    send(8'h00, 1);
    chk("00_ferr", {7'b0, ferr}, 8'd0);
    chk("00_data", rx_data, 8'h00);
    chk("00_rda", {7'b0, rda}, 8'd1);
    rd(2'd0, 8'h00, 1, "00_rd");
    send(8'h11, 1);
    send(8'h22, 1);
    chk("b2b_data", rx_data, 8'h22);
    chk("b2b_rda", {7'b0, rda}, 8'd1);
    @(negedge clk);
    iocs = 1;
    iorw = 0;
    #1;
    chk("wr_de", {7'b0, drive_en}, 8'd0);
    @(negedge clk);
    iocs = 0;
    chk("wr_rda", {7'b0, rda}, 8'd1);
`ifdef UART_RX_STATUS_EN
    rd(2'd1, 8'h05, 1, "status1");
    rd(2'd1, 8'h01, 1, "status2");
`else
    rd(2'd1, 8'h22, 0, "addr1");
    chk("addr1_rda", {7'b0, rda}, 8'd1);
`endif
    rd(2'd0, 8'h22, 1, "22_rd");
    chk("22_rda_clr", {7'b0, rda}, 8'd0);
    rxd = 0;
    idle(48);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      idle(48);
    end
    idle(24);
    rst = 1;
    rxd = 1;
    idle(2);
    rst = 0;
    chk("midrst_rda", {7'b0, rda}, 8'd0);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_ferr", {7'b0, ferr}, 8'd0);
    idle(96);
    send(8'h5A, 1);
    chk("5a_data", rx_data, 8'h5A);
    chk("5a_rda", {7'b0, rda}, 8'd1);
    chk("5a_ferr", {7'b0, ferr}, 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
